decode_issue_ctrl: RTL and testbench
====================================

// Module: decode_issue_ctrl
// PURPOSE
//  Decode/issue controller for the RV32 reduced-ISA pipeline; owns the IF/ID and ID/EX registers.
//  Decodes the ID instruction, builds its immediate, detects RAW hazards against in-flight writers
//  and issues to EX with valid/ready. Inserts bubbles on hazard, drops work on branch flush, counts stalls.
// PARAMETERS
//  XLEN   32  datapath / immediate width
//  CNT_W  16  width of the saturating stall counter
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  if_valid     in   1     fetch presents an instruction
//  if_instr     in   32    fetched instruction
//  if_pc        in   XLEN  PC of if_instr
//  id_ready     out  1     IF/ID can accept (if_valid&&id_ready = fetch handshake)
//  flush        in   1     branch/jump taken in EX: kill ID and ID/EX contents
//  ex_ready     in   1     EX consumes ID/EX this cycle; the pipeline advances
//  ex_valid     out  1     ID/EX register holds a live instruction
//  ex_instr     out  32    issued instruction;  ex_pc out XLEN issued PC
//  ex_imm       out  XLEN  sign-extended immediate (I/S/B/J formats, 0 otherwise)
//  ex_rs1/ex_rs2/ex_rd  out 5  register fields
//  ex_illegal   out  1     opcode not in the supported set
//  ex_fwd_a/ex_fwd_b    out 2  operand source (FORWARD_EN only, else tied 2'b00)
//  stall_cnt    out  CNT_W cycles a valid ID instruction was held by a hazard
// BEHAVIOUR
//  Reset: all valids 0, id_ready 1, ex_* 0, scoreboard empty, stall_cnt 0, FSM EMPTY.
//  FSM on IF/ID: EMPTY -> FULL on fetch handshake; FULL -> issue -> EMPTY, or FULL again if a new fetch lands
//   the same cycle; FULL -> STALL when hazard or ID/EX blocked; STALL -> FULL when cleared.
//  Issue condition: id_valid && !hazard && (!ex_valid || ex_ready). ID/EX loaded next edge: latency 1.
//  id_ready = !id_valid || issue. If ex_ready && !issue, ex_valid <= 0 (bubble).
//  Writer: rd!=0 and opcode in {OPTIPOR,OPIMEDIATO,OPLOAD,OPJAL,OPJALR}.
//  rs1 used: OPTIPOR,OPIMEDIATO,OPLOAD,OPSTORE,OPBRANCH,OPJALR; rs2 used: OPTIPOR,OPSTORE,OPBRANCH.
//  Scoreboard (2 entries {wr,rd,load}): sb0=EX/MEM, sb1=MEM/WB. On ex_ready: sb1<=sb0; sb0<=ID/EX info
//   (zeroed if !ex_valid). Register file is write-before-read, so WB needs no tracking.
//  Immediate: I {20{i31},i[31:20]}; S {20{i31},i[31:25],i[11:7]}; B {20{i31},i7,i[30:25],i[11:8],0};
//   J {12{i31},i[19:12],i20,i[30:21],0}; any other opcode -> 0 and ex_illegal=1 (never X).
//  Flush: id_valid<=0, ex_valid<=0 same edge; fetch handshake that cycle is discarded; scoreboard kept
//   (older instructions); FSM -> EMPTY. Flush dominates issue and hazard.
//  stall_cnt +1 per cycle in STALL, saturates at all-ones, no wrap. Reset mid-stall returns to reset values.
// CONFIGURATION
//  FORWARD_EN defined: hazard only when ID/EX holds a load writing a used rs (1 bubble). ex_fwd_x registered
//   at issue: 01 = rs matches sb0 rd (EX/MEM), 10 = sb1 rd, 00 = regfile; the younger match wins.
//  FORWARD_EN undefined: hazard on any used rs matching a writer in ID/EX, sb0 or sb1; ex_fwd_x = 00.
// STRUCTURE
//  params.v: opcode constants (OPTIPOR..OPJAL), FSM state encodings, forward-select encodings.
//  Sub-module imm_builder (combinational immediate + illegal flag) instantiated once on the IF/ID instruction.
// TESTING
//  beq x0,x0,-4 (0xFE000EE3) issued -> ex_imm=0xFFFFFFFC, ex_valid 1 cycle after fetch; jal x1,8 (0x008000EF) -> ex_imm=8.
//  lw x5,0(x1); add x6,x5,x2 with FORWARD_EN -> 1 bubble, add issues with ex_fwd_a=01; without -> 3 bubbles, stall_cnt=3.
//  addi x0,x0,1 then add x3,x0,x0 -> no stall (rd=0 never a writer).
//  ex_ready=0 for 4 cycles with ID full -> id_ready=0, ID/EX held stable, no fetch lost or duplicated.
//  flush coincident with a hazard and a fetch -> ex_valid=0, id_valid=0 next cycle, fetched instruction dropped.
//  opcode 0x7F -> ex_illegal=1, ex_imm=0; rst_n low in STALL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared opcodes, state/forward encodings and decode helpers for the decode/issue controller.
package decode_issue_ctrl_pkg;

  localparam logic [6:0] OPTIPOR    = 7'b0110011;
  localparam logic [6:0] OPIMEDIATO = 7'b0010011;
  localparam logic [6:0] OPLOAD     = 7'b0000011;
  localparam logic [6:0] OPSTORE    = 7'b0100011;
  localparam logic [6:0] OPBRANCH   = 7'b1100011;
  localparam logic [6:0] OPJALR     = 7'b1100111;
  localparam logic [6:0] OPJAL      = 7'b1101111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_t;

  typedef struct packed {
    logic       wr;
    logic [4:0] rd;
  } sb_entry_t;

  function automatic logic is_writer(input logic [6:0] opc, input logic [4:0] rd);
    return (rd != 5'd0) && (opc inside {OPTIPOR, OPIMEDIATO, OPLOAD, OPJAL, OPJALR});
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return opc inside {OPTIPOR, OPIMEDIATO, OPLOAD, OPSTORE, OPBRANCH, OPJALR};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return opc inside {OPTIPOR, OPSTORE, OPBRANCH};
  endfunction

  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] rs);
    return e.wr && (e.rd == rs);
  endfunction

  // The younger (EX/MEM) producer wins over MEM/WB.
  function automatic fwd_t fwd_pick(input logic used, input logic [4:0] rs,
                                    input sb_entry_t s0, input sb_entry_t s1);
    if (used && sb_hit(s0, rs)) return FWD_EXMEM;
    if (used && sb_hit(s1, rs)) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Decode/issue bus: fetch handshake, branch flush, EX handshake and the ID/EX issue outputs.
interface decode_issue_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [XLEN-1:0]  if_pc;
  logic             id_ready;
  logic             flush;
  logic             ex_ready;
  logic             ex_valid;
  logic [31:0]      ex_instr;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_illegal;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  id_ready, ex_valid, ex_instr, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_illegal, ex_fwd_a, ex_fwd_b, stall_cnt
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output id_ready, ex_valid, ex_instr, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_illegal, ex_fwd_a, ex_fwd_b, stall_cnt
  );
endinterface

// File: rtl/decode_issue_ctrl_imm_builder.sv
// Combinational immediate builder for the I/S/B/J formats plus the unsupported-opcode flag.
module decode_issue_ctrl_imm_builder
  import decode_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (instr[6:0])
      OPTIPOR: ;
      OPIMEDIATO, OPLOAD, OPJALR:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPSTORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPBRANCH:
        imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPJAL:
        imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller owning the IF/ID and ID/EX registers, RAW scoreboard and stall counter.
// Build option: define FORWARD_EN to enable operand forwarding (only load-use stalls remain).
//
//   state    | meaning
//   ST_EMPTY | IF/ID holds no instruction
//   ST_FULL  | IF/ID holds a freshly fetched instruction
//   ST_STALL | IF/ID instruction was held at least one cycle (hazard or EX busy)
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  decode_issue_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [31:0]      id_instr;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_imm;
  logic             id_illegal;
  logic             id_valid, id_ready, fetch, issue, hazard, hold;
  logic [6:0]       opc;
  logic [4:0]       rs1, rs2, rd;
  logic             use1, use2;

  logic             ex_valid, ex_illegal, ex_wr;
  logic [31:0]      ex_instr;
  logic [XLEN-1:0]  ex_pc, ex_imm;
  sb_entry_t        sb0, sb1, idex_e;
  logic [CNT_W-1:0] stall_cnt;

  assign opc  = id_instr[6:0];
  assign rd   = id_instr[11:7];
  assign rs1  = id_instr[19:15];
  assign rs2  = id_instr[24:20];
  assign use1 = uses_rs1(opc);
  assign use2 = uses_rs2(opc);

  decode_issue_ctrl_imm_builder #(.XLEN(XLEN)) u_imm_builder (
    .instr   (id_instr),
    .imm     (id_imm),
    .illegal (id_illegal)
  );

  assign id_valid = (state_q != ST_EMPTY);
  assign idex_e   = '{wr: ex_valid && ex_wr, rd: ex_instr[11:7]};
  assign issue    = id_valid && !hazard && (!ex_valid || bus.ex_ready);
  assign fetch    = bus.if_valid && id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY:           if (fetch) state_d = ST_FULL;
        ST_FULL, ST_STALL:  state_d = issue ? (fetch ? ST_FULL : ST_EMPTY) : ST_STALL;
        default:            state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    id_ready = 1'b1;
    hold     = 1'b0;
    case (state_q)
      ST_FULL, ST_STALL: begin
        id_ready = issue;
        hold     = !issue && !bus.flush;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr <= '0;
      id_pc    <= '0;
    end else if (fetch && !bus.flush) begin
      id_instr <= bus.if_instr;
      id_pc    <= bus.if_pc;
    end
  end

  // Flush dominates: a same-cycle issue is dropped, a consuming EX still retires into sb0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_instr   <= '0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_illegal <= 1'b0;
      ex_wr      <= 1'b0;
    end else if (bus.flush) begin
      ex_valid <= 1'b0;
    end else if (issue) begin
      ex_valid   <= 1'b1;
      ex_instr   <= id_instr;
      ex_pc      <= id_pc;
      ex_imm     <= id_imm;
      ex_illegal <= id_illegal;
      ex_wr      <= is_writer(opc, rd);
    end else if (bus.ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb0 <= '0;
      sb1 <= '0;
    end else if (bus.ex_ready) begin
      sb1 <= sb0;
      sb0 <= idex_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cnt <= '0;
    else if (hold && (stall_cnt != '1))     stall_cnt <= stall_cnt + CNT_W'(1);
  end

`ifdef FORWARD_EN
  fwd_t fwd_a_q, fwd_b_q;
  logic ex_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      ex_load <= 1'b0;
    end else if (!bus.flush && issue) begin
      fwd_a_q <= fwd_pick(use1, rs1, sb0, sb1);
      fwd_b_q <= fwd_pick(use2, rs2, sb0, sb1);
      ex_load <= (opc == OPLOAD);
    end
  end

  // Only a load still in ID/EX cannot be forwarded in time.
  assign hazard = ex_load && ((use1 && sb_hit(idex_e, rs1)) || (use2 && sb_hit(idex_e, rs2)));
  assign bus.ex_fwd_a = fwd_a_q;
  assign bus.ex_fwd_b = fwd_b_q;
`else
  assign hazard = (use1 && (sb_hit(idex_e, rs1) || sb_hit(sb0, rs1) || sb_hit(sb1, rs1))) ||
                  (use2 && (sb_hit(idex_e, rs2) || sb_hit(sb0, rs2) || sb_hit(sb1, rs2)));
  assign bus.ex_fwd_a = FWD_RF;
  assign bus.ex_fwd_b = FWD_RF;
`endif

  assign bus.id_ready   = id_ready;
  assign bus.ex_valid   = ex_valid;
  assign bus.ex_instr   = ex_instr;
  assign bus.ex_pc      = ex_pc;
  assign bus.ex_imm     = ex_imm;
  assign bus.ex_rs1     = ex_instr[19:15];
  assign bus.ex_rs2     = ex_instr[24:20];
  assign bus.ex_rd      = ex_instr[11:7];
  assign bus.ex_illegal = ex_illegal;
  assign bus.stall_cnt  = stall_cnt;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed pins plus randomized traffic against a pipeline-slot model.
module tb_decode_issue_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_L = 7'b0000011,
                         O_S = 7'b0100011, O_B = 7'b1100011, O_JR = 7'b1100111,
                         O_J = 7'b1101111;

  localparam logic [31:0] LW_X5   = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] ADD_X6  = 32'h00228333;  // add  x6,x5,x2
  localparam logic [31:0] ADDI_X0 = 32'h00100013;  // addi x0,x0,1
  localparam logic [31:0] ADD_X3  = 32'h000001B3;  // add  x3,x0,x0
  localparam logic [31:0] INS_A   = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] INS_B   = 32'h00200113;  // addi x2,x0,2
  localparam logic [31:0] INS_C   = 32'h00300193;  // addi x3,x0,3

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  decode_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Model: one slot per pipeline register, plus the destination regs of the two older stages.
  logic        m_id_v, m_ex_v;
  logic [31:0] m_id_instr, m_id_pc, m_ex_instr, m_ex_pc;
  logic [1:0]  m_fa, m_fb;
  int          m_sb0, m_sb1, m_stall;
  logic [31:0] consumed[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wr_rd(input logic [31:0] i);
    int r = int'(i[11:7]);
    if (r != 0 && (i[6:0] == O_R || i[6:0] == O_I || i[6:0] == O_L ||
                   i[6:0] == O_J || i[6:0] == O_JR)) return r;
    return 0;
  endfunction

  function automatic int src1(input logic [31:0] i);
    if (i[6:0] == O_R || i[6:0] == O_I || i[6:0] == O_L || i[6:0] == O_S ||
        i[6:0] == O_B || i[6:0] == O_JR) return int'(i[19:15]);
    return -1;
  endfunction

  function automatic int src2(input logic [31:0] i);
    if (i[6:0] == O_R || i[6:0] == O_S || i[6:0] == O_B) return int'(i[24:20]);
    return -1;
  endfunction

  function automatic bit dep(input int r, input int w);
    return (r > 0) && (r == w);
  endfunction

  // {illegal, imm}: immediates as signed integer values, weighted field by field.
  function automatic logic [32:0] exp_imm(input logic [31:0] i);
    int v;
    case (i[6:0])
      O_R:            v = 0;
      O_I, O_L, O_JR: v = int'(i[30:20]) - (i[31] ? 2048 : 0);
      O_S:            v = int'(i[30:25]) * 32 + int'(i[11:7]) - (i[31] ? 2048 : 0);
      O_B:            v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2
                          - (i[31] ? 4096 : 0);
      O_J:            v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2
                          - (i[31] ? 1048576 : 0);
      default:        return {1'b1, 32'h0};
    endcase
    return {1'b0, 32'(v)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i = $urandom;
    logic [6:0] ops[8] = '{O_R, O_I, O_L, O_S, O_B, O_J, O_JR, 7'h7F};
    i[6:0]   = ops[$urandom_range(0, 7)];
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.flush = 1'b0; bus.ex_ready = 1'b0;
    #1;
    chk("rst_ex_valid",  32'(bus.ex_valid),  32'd0);
    chk("rst_id_ready",  32'(bus.id_ready),  32'd1);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_ex_instr",  bus.ex_instr,       32'd0);
    chk("rst_ex_imm",    bus.ex_imm,         32'd0);
    chk("rst_ex_fwd",    32'({bus.ex_fwd_a, bus.ex_fwd_b}), 32'd0);
    @(posedge clk); #1;
    m_id_v = 0; m_ex_v = 0; m_id_instr = '0; m_id_pc = '0; m_ex_instr = '0; m_ex_pc = '0;
    m_fa = 0; m_fb = 0; m_sb0 = 0; m_sb1 = 0; m_stall = 0;
    consumed.delete();
    rst_n = 1'b1;
  endtask

  // One clock: drive, check id_ready before the edge, advance the model, check registered outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic er);
    bit hz, iss, rdy;
    int r1, r2, wa;
    logic [1:0] nfa, nfb;
    logic [32:0] e;
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc; bus.flush = fl; bus.ex_ready = er;
    #1;
    r1 = src1(m_id_instr);
    r2 = src2(m_id_instr);
    wa = m_ex_v ? wr_rd(m_ex_instr) : 0;
`ifdef FORWARD_EN
    hz  = (m_ex_instr[6:0] == O_L) && (dep(r1, wa) || dep(r2, wa));
    nfa = dep(r1, m_sb0) ? 2'b01 : dep(r1, m_sb1) ? 2'b10 : 2'b00;
    nfb = dep(r2, m_sb0) ? 2'b01 : dep(r2, m_sb1) ? 2'b10 : 2'b00;
`else
    hz  = dep(r1, wa) || dep(r1, m_sb0) || dep(r1, m_sb1) ||
          dep(r2, wa) || dep(r2, m_sb0) || dep(r2, m_sb1);
    nfa = 2'b00;
    nfb = 2'b00;
`endif
    iss = m_id_v && !hz && (!m_ex_v || er);
    rdy = !m_id_v || iss;
    chk("id_ready", 32'(bus.id_ready), 32'(rdy));
    if (bus.ex_valid && er) consumed.push_back(bus.ex_instr);
    @(posedge clk); #1;
    if (er) begin
      m_sb1 = m_sb0;
      m_sb0 = wa;
    end
    if (m_id_v && !iss && !fl && m_stall < SAT) m_stall++;
    if (fl) m_ex_v = 0;
    else if (iss) begin
      m_ex_v = 1; m_ex_instr = m_id_instr; m_ex_pc = m_id_pc; m_fa = nfa; m_fb = nfb;
    end else if (er) m_ex_v = 0;
    if (fl) m_id_v = 0;
    else if (rdy && v) begin
      m_id_v = 1; m_id_instr = ins; m_id_pc = pc;
    end else if (iss) m_id_v = 0;
    chk("ex_valid",  32'(bus.ex_valid),  32'(m_ex_v));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    if (m_ex_v) begin
      e = exp_imm(m_ex_instr);
      chk("ex_instr",   bus.ex_instr,        m_ex_instr);
      chk("ex_pc",      bus.ex_pc,           m_ex_pc);
      chk("ex_imm",     bus.ex_imm,          e[31:0]);
      chk("ex_illegal", 32'(bus.ex_illegal), 32'(e[32]));
      chk("ex_regs",    32'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd}),
          32'({m_ex_instr[19:15], m_ex_instr[24:20], m_ex_instr[11:7]}));
      chk("ex_fwd_a",   32'(bus.ex_fwd_a),   32'(m_fa));
      chk("ex_fwd_b",   32'(bus.ex_fwd_b),   32'(m_fb));
    end
  endtask

  task automatic idle(input int n, input logic er);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, er);
  endtask

  initial begin
    int bubbles;
    bit found;
    #2;
    do_reset();

    // Branch and jump immediates, issued one cycle after landing in IF/ID.
    step(1'b1, 32'hFE000EE3, 32'h100, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("beq_valid", 32'(bus.ex_valid), 32'd1);
    chk("beq_imm",   bus.ex_imm,        32'hFFFFFFFC);
    step(1'b1, 32'h008000EF, 32'h104, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("jal_imm",   bus.ex_imm,        32'd8);

    // Load-use: bubbles between lw and add.
    do_reset();
    step(1'b1, LW_X5, 32'h0, 1'b0, 1'b1);
    step(1'b1, ADD_X6, 32'h4, 1'b0, 1'b1);
    bubbles = 0;
    found   = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (bus.ex_valid && bus.ex_instr == ADD_X6) found = 1;
      else if (!bus.ex_valid) bubbles++;
    end
    chk("lw_add_issued", 32'(found), 32'd1);
`ifdef FORWARD_EN
    chk("lw_add_bubbles", 32'(bubbles),           32'd1);
    chk("lw_add_stall",   32'(bus.stall_cnt),     32'd1);
    chk("lw_add_fwd_a",   32'(bus.ex_fwd_a),      32'd1);
`else
    chk("lw_add_bubbles", 32'(bubbles),           32'd3);
    chk("lw_add_stall",   32'(bus.stall_cnt),     32'd3);
    chk("lw_add_fwd_a",   32'(bus.ex_fwd_a),      32'd0);
`endif

    // rd=x0 is never a writer.
    do_reset();
    step(1'b1, ADDI_X0, 32'h0, 1'b0, 1'b1);
    step(1'b1, ADD_X3, 32'h4, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("rd0_issue", bus.ex_instr, ADD_X3);
    chk("rd0_stall", 32'(bus.stall_cnt), 32'd0);

    // EX back-pressure for 4 cycles with ID full.
    do_reset();
    step(1'b1, INS_A, 32'h0, 1'b0, 1'b1);
    step(1'b1, INS_B, 32'h4, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, INS_C, 32'h8, 1'b0, 1'b0);
      chk("hold_id_ready", 32'(bus.id_ready), 32'd0);
      chk("hold_ex_instr", bus.ex_instr, INS_A);
    end
    chk("hold_stall", 32'(bus.stall_cnt), 32'd4);
    step(1'b1, INS_C, 32'h8, 1'b0, 1'b1);
    idle(4, 1'b1);
    chk("hold_count", 32'(consumed.size()), 32'd3);
    if (consumed.size() == 3) begin
      chk("hold_seq0", consumed[0], INS_A);
      chk("hold_seq1", consumed[1], INS_B);
      chk("hold_seq2", consumed[2], INS_C);
    end

    // Stall counter saturates instead of wrapping.
    do_reset();
    step(1'b1, INS_A, 32'h0, 1'b0, 1'b1);
    step(1'b1, INS_B, 32'h4, 1'b0, 1'b1);
    idle(20, 1'b0);
    chk("stall_sat", 32'(bus.stall_cnt), 32'(SAT));

    // Flush with a hazard pending and a fetch presented.
    do_reset();
    step(1'b1, LW_X5, 32'h0, 1'b0, 1'b1);
    step(1'b1, ADD_X6, 32'h4, 1'b0, 1'b1);
    step(1'b1, INS_C, 32'h8, 1'b1, 1'b1);
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_id_empty", 32'(bus.id_ready), 32'd1);
    idle(4, 1'b1);
    chk("flush_count", 32'(consumed.size()), 32'd1);
    if (consumed.size() == 1) chk("flush_seq0", consumed[0], LW_X5);

    // Unsupported opcode.
    do_reset();
    step(1'b1, 32'h0000007F, 32'h0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("illegal_flag", 32'(bus.ex_illegal), 32'd1);
    chk("illegal_imm",  bus.ex_imm,          32'd0);

    // Reset while stalled.
    do_reset();
    step(1'b1, LW_X5, 32'h0, 1'b0, 1'b1);
    step(1'b1, ADD_X6, 32'h4, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("pre_rst_stall", 32'(bus.stall_cnt), 32'd1);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step($urandom_range(0, 9) < 7, rand_instr(), {$urandom_range(0, 16'hFFFF), 2'b00},
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
